// File: rtl/vec_int_ctrl_if.sv
// Request/redirect bundle between the datapath (master) and the vectored interrupt controller (slave).
interface vec_int_ctrl_if #(
  parameter int unsigned NUM_SRC = 4,
  parameter int unsigned ADDR_W  = 32
);
  logic [NUM_SRC-1:0] irq;
  logic [NUM_SRC-1:0] irq_mask;
  logic [ADDR_W-1:0]  pc_next;
  logic               eret;
  logic               int_ack;
  logic [ADDR_W-1:0]  int_addr;
  logic [ADDR_W-1:0]  epc;
  logic               in_service;
  logic [3:0]         cur_id;
  logic [NUM_SRC-1:0] pending;

  modport master (
    output irq, irq_mask, pc_next, eret,
    input  int_ack, int_addr, epc, in_service, cur_id, pending
  );

  modport slave (
    input  irq, irq_mask, pc_next, eret,
    output int_ack, int_addr, epc, in_service, cur_id, pending
  );
endinterface

// File: rtl/vec_int_ctrl.sv
// Vectored interrupt controller: pending/mask/fixed-priority grant, PC redirect,
// EPC capture and non-nesting service state released by jepc.
module vec_int_ctrl #(
  parameter int unsigned        NUM_SRC    = 4,
  parameter int unsigned        ADDR_W     = 32,
  parameter logic [ADDR_W-1:0]  VEC_BASE   = ADDR_W'(32'h0000_01F0),
  parameter int unsigned        VEC_STRIDE = 4,
  parameter logic [NUM_SRC-1:0] EDGE_MASK  = '1
) (
  input  logic          clk,
  input  logic          reset_n,
  vec_int_ctrl_if.slave ctrl_if
);

  typedef enum logic {
    IDLE    = 1'b0,
    SERVICE = 1'b1
  } state_e;

  state_e             state_q, state_d;
  logic [NUM_SRC-1:0] irq_dly_q;
  logic [NUM_SRC-1:0] pending_q, pending_d;
  logic [ADDR_W-1:0]  epc_q, epc_d;
  logic [3:0]         cur_id_q, cur_id_d;

  logic [NUM_SRC-1:0] set_c, clr_c, active_c;
  logic [3:0]         gnt_id_c, addr_id_c;
  logic               ack_c;

  // Edge channels fire only on a 0->1 transition, level channels every cycle high.
  assign set_c     = ctrl_if.irq & (~irq_dly_q | ~EDGE_MASK);
  assign active_c  = pending_q & ctrl_if.irq_mask;
  assign ack_c     = (state_q == IDLE) && (|active_c);
  assign pending_d = set_c | (pending_q & ~clr_c);

  // Lowest active index wins.
  always_comb begin
    gnt_id_c = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (active_c[i]) gnt_id_c = 4'(i);
    end
  end

  always_comb begin
    state_d  = state_q;
    epc_d    = epc_q;
    cur_id_d = cur_id_q;
    clr_c    = '0;
    case (state_q)
      IDLE: begin
        if (ack_c) begin
          state_d  = SERVICE;
          epc_d    = ctrl_if.pc_next;
          cur_id_d = gnt_id_c;
          for (int i = 0; i < NUM_SRC; i++) begin
            clr_c[i] = (gnt_id_c == 4'(i));
          end
        end
      end
      SERVICE: begin
        if (ctrl_if.eret) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      irq_dly_q <= '0;
      pending_q <= '0;
      epc_q     <= '0;
      cur_id_q  <= '0;
    end else begin
      state_q   <= state_d;
      irq_dly_q <= ctrl_if.irq;
      pending_q <= pending_d;
      epc_q     <= epc_d;
      cur_id_q  <= cur_id_d;
    end
  end

  // Vector tracks the live grant while acking, otherwise the channel in service.
  assign addr_id_c = ack_c ? gnt_id_c : cur_id_q;

  assign ctrl_if.int_ack    = ack_c;
  assign ctrl_if.int_addr   = VEC_BASE + ADDR_W'(addr_id_c) * ADDR_W'(VEC_STRIDE);
  assign ctrl_if.epc        = epc_q;
  assign ctrl_if.in_service = (state_q == SERVICE);
  assign ctrl_if.cur_id     = cur_id_q;
  assign ctrl_if.pending    = pending_q;

endmodule

// File: tb/tb_vec_int_ctrl.sv
// Scoreboard bench for vec_int_ctrl: directed test-plan scenarios plus random traffic.
module tb_vec_int_ctrl;

  localparam int unsigned NS   = 4;
  localparam int unsigned AW   = 32;
  localparam logic [31:0] BASE = 32'h0000_01F0;
  localparam int unsigned STR  = 4;
  localparam logic [3:0]  EM   = 4'b1110;

  logic clk;
  logic reset_n;

  vec_int_ctrl_if #(.NUM_SRC(NS), .ADDR_W(AW)) bus ();

  vec_int_ctrl #(
    .NUM_SRC(NS), .ADDR_W(AW), .VEC_BASE(BASE), .VEC_STRIDE(STR), .EDGE_MASK(EM)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .ctrl_if (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: state after the next edge, plus a snapshot of the current cycle.
  typedef struct {
    logic [31:0] addr;
    logic [31:0] epc;
    int          id;
  } grant_t;
  grant_t sb_q[$];

  logic [3:0]  m_pend, m_prev;
  logic        m_busy;
  logic [31:0] m_epc;
  int          m_cur;
  logic [3:0]  e_pend;
  logic        e_busy, e_ack;
  logic [31:0] e_epc;
  int          e_cur;

  always @(negedge clk) begin
    logic [3:0] act, nxt;
    int g;
    if (!reset_n) begin
      m_pend = '0; m_prev = '0; m_busy = 1'b0; m_epc = '0; m_cur = 0;
      e_pend = '0; e_busy = 1'b0; e_ack = 1'b0; e_epc = '0; e_cur = 0;
      sb_q.delete();
    end else begin
      e_pend = m_pend; e_busy = m_busy; e_epc = m_epc; e_cur = m_cur;
      act   = m_pend & bus.irq_mask;
      e_ack = !m_busy && (act != 0);
      g = 0;
      for (int i = NS - 1; i >= 0; i--) if (act[i]) g = i;
      nxt = m_pend;
      if (e_ack) begin
        nxt[g] = 1'b0;
        m_busy = 1'b1;
        m_epc  = bus.pc_next;
        m_cur  = g;
        sb_q.push_back('{addr: BASE + 32'(g) * 32'(STR), epc: bus.pc_next, id: g});
      end else if (m_busy && bus.eret) begin
        m_busy = 1'b0;
      end
      for (int i = 0; i < NS; i++) begin
        if (bus.irq[i] && (!EM[i] || !m_prev[i])) nxt[i] = 1'b1;
      end
      m_pend = nxt;
      m_prev = bus.irq;
    end
  end

  // Monitor: per-cycle state compare and grant scoreboard.
  logic        epc_due = 1'b0;
  grant_t      last_g;
  always @(negedge clk) begin
    #1;
    if (!reset_n) begin
      epc_due = 1'b0;
    end else begin
      if (epc_due) begin
        chk("grant_epc", bus.epc, last_g.epc);
        chk("grant_cur_id", 32'(bus.cur_id), 32'(last_g.id));
        epc_due = 1'b0;
      end
      chk("int_ack", 32'(bus.int_ack), 32'(e_ack));
      chk("pending", 32'(bus.pending), 32'(e_pend));
      chk("in_service", 32'(bus.in_service), 32'(e_busy));
      chk("epc", bus.epc, e_epc);
      chk("cur_id", 32'(bus.cur_id), 32'(e_cur));
      if (bus.int_ack) begin
        if (sb_q.size() == 0) begin
          chk("unexpected_grant", 32'(bus.int_ack), 32'd0);
        end else begin
          last_g = sb_q.pop_front();
          chk("grant_addr", bus.int_addr, last_g.addr);
          epc_due = 1'b1;
        end
      end else begin
        chk("idle_addr", bus.int_addr, BASE + 32'(e_cur) * 32'(STR));
        sb_q.delete();
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
    #2;
  endtask

  initial begin
    reset_n      = 1'b0;
    bus.irq      = '0;
    bus.irq_mask = 4'b1111;
    bus.pc_next  = '0;
    bus.eret     = 1'b0;
    #1;
    chk("rst_ack", 32'(bus.int_ack), 32'd0);
    chk("rst_addr", bus.int_addr, BASE);
    chk("rst_in_service", 32'(bus.in_service), 32'd0);
    chk("rst_pending", 32'(bus.pending), 32'd0);
    chk("rst_epc", bus.epc, 32'd0);
    tick(); tick();
    reset_n = 1'b1;
    repeat (8) tick();

    // Edge, single
    bus.irq = 4'b0010; bus.pc_next = 32'h40;
    tick();
    sample();
    chk("edge_ack", 32'(bus.int_ack), 32'd1);
    chk("edge_addr", bus.int_addr, 32'h1F4);
    tick();
    sample();
    chk("edge_epc", bus.epc, 32'h40);
    chk("edge_cur_id", 32'(bus.cur_id), 32'd1);
    chk("edge_in_service", 32'(bus.in_service), 32'd1);
    chk("edge_pending", 32'(bus.pending), 32'd0);
    tick();
    bus.eret = 1'b1; bus.irq = '0;
    tick();
    bus.eret = 1'b0;
    repeat (3) tick();

    // Priority: channels 3 and 0 together
    bus.irq = 4'b1001; bus.pc_next = 32'h100;
    tick();
    bus.irq = 4'b1000;
    sample();
    chk("prio_addr0", bus.int_addr, 32'h1F0);
    tick();
    sample();
    chk("prio_pending", 32'(bus.pending), 32'b1000);
    tick();
    bus.eret = 1'b1;
    tick();
    bus.eret = 1'b0;
    sample();
    chk("prio_ack3", 32'(bus.int_ack), 32'd1);
    chk("prio_addr3", bus.int_addr, 32'h1FC);
    tick();
    bus.eret = 1'b1; bus.irq = '0;
    tick();
    bus.eret = 1'b0;
    repeat (3) tick();

    // Mask holds channel 2 pending
    bus.irq_mask = 4'b1011; bus.irq = 4'b0100;
    tick();
    bus.irq = '0;
    for (int k = 0; k < 20; k++) begin
      sample();
      chk("mask_no_ack", 32'(bus.int_ack), 32'd0);
      chk("mask_pending2", 32'(bus.pending[2]), 32'd1);
      tick();
    end
    bus.irq_mask = 4'b1111;
    sample();
    chk("unmask_ack", 32'(bus.int_ack), 32'd1);
    chk("unmask_addr", bus.int_addr, 32'h1F8);
    tick();
    bus.eret = 1'b1;
    tick();
    bus.eret = 1'b0;
    repeat (3) tick();

    // Set/clear collision on channel 1
    bus.irq_mask = 4'b1101; bus.irq = 4'b0010;
    tick();
    bus.irq = '0;
    tick();
    bus.irq_mask = 4'b1111; bus.irq = 4'b0010; bus.pc_next = 32'h200;
    sample();
    chk("coll_addr", bus.int_addr, 32'h1F4);
    tick();
    sample();
    chk("coll_pending1", 32'(bus.pending[1]), 32'd1);
    bus.irq = '0;
    tick();
    bus.eret = 1'b1;
    tick();
    bus.eret = 1'b0;
    sample();
    chk("coll_regrant", 32'(bus.int_ack), 32'd1);
    chk("coll_regrant_addr", bus.int_addr, 32'h1F4);
    tick();
    bus.eret = 1'b1;
    tick();
    bus.eret = 1'b0;
    repeat (3) tick();

    // Level channel 0 held high
    bus.irq = 4'b0001; bus.pc_next = 32'h300;
    tick();
    tick();
    sample();
    chk("lvl_in_service", 32'(bus.in_service), 32'd1);
    chk("lvl_repend", 32'(bus.pending), 32'b0001);
    tick();
    bus.eret = 1'b1;
    tick();
    bus.eret = 1'b0;
    bus.irq  = '0;
    sample();
    chk("lvl_regrant", 32'(bus.int_ack), 32'd1);
    chk("lvl_regrant_addr", bus.int_addr, 32'h1F0);
    tick();
    bus.eret = 1'b1;
    tick();
    bus.eret = 1'b0;
    sample();
    chk("lvl_drop_pending", 32'(bus.pending), 32'd0);
    chk("lvl_drop_no_ack", 32'(bus.int_ack), 32'd0);
    repeat (3) tick();

    // Asynchronous reset while in service
    bus.irq = 4'b0010; bus.pc_next = 32'h400;
    tick();
    bus.irq = '0;
    tick();
    bus.irq = 4'b0100;
    tick();
    bus.irq = '0;
    tick();
    #2;
    reset_n = 1'b0;
    #1;
    chk("arst_in_service", 32'(bus.in_service), 32'd0);
    chk("arst_pending", 32'(bus.pending), 32'd0);
    chk("arst_epc", bus.epc, 32'd0);
    chk("arst_ack", 32'(bus.int_ack), 32'd0);
    tick(); tick();
    reset_n = 1'b1;
    repeat (3) tick();

    // Random traffic
    for (int k = 0; k < 2000; k++) begin
      bus.irq      = 4'($urandom & $urandom & $urandom);
      bus.irq_mask = ($urandom_range(0, 7) == 0) ? 4'($urandom) : 4'hF;
      bus.eret     = ($urandom_range(0, 3) == 0);
      bus.pc_next  = $urandom & 32'hFFFF_FFFC;
      tick();
    end
    bus.irq = '0; bus.eret = 1'b0;
    repeat (4) tick();
    sample();
    chk("sb_drained", 32'(sb_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
